// File: rtl/enviar_dac_pkg.sv
// Shared constants and state encoding for the serial DAC transmitter and its ADC counterpart.
package enviar_dac_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_t;

    localparam int unsigned FrameWidth  = 16;
    localparam int unsigned DataBits    = 12;
    localparam logic [3:0]  FrameHeader = 4'b0011;

    function automatic int unsigned div_width(input int unsigned div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/enviar_dac_sclk_divider.sv
// Serial clock generator: toggles sclk every CLK_DIV enabled cycles and flags the edge about to occur.
module sclk_divider
    import enviar_dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int unsigned DivW = div_width(CLK_DIV);

    logic [DivW-1:0] cnt_q;
    logic            sclk_q;
    logic            wrap;

    always_comb begin
        wrap = enable && (cnt_q == DivW'(CLK_DIV - 1));
        rise = wrap && !sclk_q;
        fall = wrap && sclk_q;
        sclk = sclk_q;
    end

    // Disabling clears the phase so every frame starts from a known low half-period.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!enable) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/enviar_dac.sv
// Sends one header+sample frame MSB-first to an SPI-style DAC per accepted start request.
module enviar_dac
    import enviar_dac_pkg::*;
#(
    parameter int unsigned WIDTH     = FrameWidth,
    parameter int unsigned DATA_BITS = DataBits,
    parameter logic [WIDTH-DATA_BITS-1:0] HEADER = (WIDTH-DATA_BITS)'(FrameHeader),
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inicio,
    input  logic [DATA_BITS-1:0] dato,
    output logic                 sclk_out,
    output logic                 datoDAC,
    output logic                 CS_out,
    output logic                 ocupado,
    output logic                 listo
);

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [4:0]       bit_cnt_q;
    logic             cs_q;
    logic             dato_dac_q;
    logic             ocupado_q;
    logic             listo_q;

    logic sclk_fall;
    logic sclk_rise;
    logic sclk;
    logic unused_rise;

    sclk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_divider (
        .clock (clock),
        .reset (reset),
        .enable(state_q == StShift),
        .rise  (sclk_rise),
        .fall  (sclk_fall),
        .sclk  (sclk)
    );

    // The DAC samples on the rising edge; nothing here needs to act on it.
    assign unused_rise = sclk_rise;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            cs_q       <= 1'b1;
            dato_dac_q <= 1'b0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    listo_q <= 1'b0;
                    cs_q    <= 1'b1;
                    if (inicio) begin
                        shift_q    <= {HEADER, dato};
                        bit_cnt_q  <= 5'(WIDTH - 1);
                        dato_dac_q <= HEADER[WIDTH-DATA_BITS-1];
                        cs_q       <= 1'b0;
                        ocupado_q  <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    if (sclk_fall) begin
                        if (bit_cnt_q != 5'd0) begin
                            shift_q    <= shift_q << 1;
                            dato_dac_q <= shift_q[WIDTH-2];
                            bit_cnt_q  <= bit_cnt_q - 5'd1;
                        end else begin
                            cs_q       <= 1'b1;
                            listo_q    <= 1'b1;
                            ocupado_q  <= 1'b0;
                            dato_dac_q <= 1'b0;
                            state_q    <= StDone;
                        end
                    end
                end
                StDone: begin
                    listo_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        sclk_out = sclk;
        datoDAC  = dato_dac_q;
        CS_out   = cs_q;
        ocupado  = ocupado_q;
        listo    = listo_q;
    end

endmodule

// File: tb/tb_enviar_dac.sv
// Self-checking bench for enviar_dac: default divider and CLK_DIV=1 instances.
module tb_enviar_dac;

    logic        clock;
    logic        reset;
    logic        inicio1, inicio2;
    logic [11:0] dato1, dato2;
    logic        sclk1, dac1, cs1, ocup1, listo1;
    logic        sclk2, dac2, cs2, ocup2, listo2;

    int checks;
    int errors;

    enviar_dac u_dut1 (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio1),
        .dato    (dato1),
        .sclk_out(sclk1),
        .datoDAC (dac1),
        .CS_out  (cs1),
        .ocupado (ocup1),
        .listo   (listo1)
    );

    enviar_dac #(
        .CLK_DIV(1)
    ) u_dut2 (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio2),
        .dato    (dato2),
        .sclk_out(sclk2),
        .datoDAC (dac2),
        .CS_out  (cs2),
        .ocupado (ocup2),
        .listo   (listo2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: the frame is the header followed by the sample; each bit spans two
    // half-periods of CLK_DIV system clocks.
    function automatic logic [15:0] model_frame(input logic [11:0] d);
        logic [3:0] hdr;
        hdr = 4'b0011;
        return {hdr, d};
    endfunction

    function automatic int model_cs_low(input int sel);
        int div;
        div = (sel == 1) ? 1 : 2;
        return 2 * 16 * div;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic g_cs(input int sel);
        return (sel == 1) ? cs2 : cs1;
    endfunction
    function automatic logic g_sclk(input int sel);
        return (sel == 1) ? sclk2 : sclk1;
    endfunction
    function automatic logic g_dac(input int sel);
        return (sel == 1) ? dac2 : dac1;
    endfunction
    function automatic logic g_ocup(input int sel);
        return (sel == 1) ? ocup2 : ocup1;
    endfunction
    function automatic logic g_listo(input int sel);
        return (sel == 1) ? listo2 : listo1;
    endfunction

    task automatic set_in(input int sel, input logic go, input logic [11:0] d);
        if (sel == 1) begin
            inicio2 = go;
            dato2   = d;
        end else begin
            inicio1 = go;
            dato1   = d;
        end
    endtask

    task automatic set_go(input int sel, input logic go);
        if (sel == 1) inicio2 = go;
        else          inicio1 = go;
    endtask

    task automatic start(input int sel, input logic [11:0] d);
        @(negedge clock);
        set_in(sel, 1'b1, d);
    endtask

    // Watches one frame from the first CS_out-low cycle (index 1) until listo plus `extra` cycles.
    task automatic capture(input int sel, input bit hold, input int extra,
                           input int dist_at, input logic [11:0] dist_dato,
                           output logic [15:0] bits, output int nrise, output int cs_low,
                           output int listo_idx, output int listo_cnt, output int waited,
                           output int viol);
        logic prev;
        int   after;
        bits = '0; nrise = 0; cs_low = 0; listo_idx = 0; listo_cnt = 0;
        waited = 0; viol = 0; prev = 1'b0; after = 0;
        @(negedge clock);
        while (g_cs(sel) && waited < 300) begin
            waited++;
            @(negedge clock);
        end
        if (!hold) set_go(sel, 1'b0);
        for (int i = 1; i < 400; i++) begin
            if (i > 1) @(negedge clock);
            if (dist_at != 0 && i == dist_at) set_in(sel, 1'b1, dist_dato);
            if (dist_at != 0 && i == dist_at + 1) set_go(sel, 1'b0);
            if (listo_idx != 0) after++;
            if (g_sclk(sel) && !prev) begin
                bits = {bits[14:0], g_dac(sel)};
                nrise++;
            end
            prev = g_sclk(sel);
            if (g_cs(sel) && g_sclk(sel)) viol++;
            if (listo_idx == 0 && !g_cs(sel)) begin
                cs_low++;
                if (!g_ocup(sel)) viol++;
            end
            if (g_listo(sel)) begin
                listo_cnt++;
                if (listo_idx == 0) begin
                    listo_idx = i;
                    if (g_ocup(sel) || !g_cs(sel)) viol++;
                end
            end
            if (after > 0 && !hold && !g_cs(sel)) viol++;
            if (listo_idx != 0 && after >= extra) break;
        end
    endtask

    task automatic check_frame(input string tag, input int sel, input logic [15:0] exp_bits,
                               input int exp_cs, input bit hold, input int extra,
                               input int dist_at, input logic [11:0] dist_dato,
                               input int exp_wait);
        logic [15:0] bits;
        int nrise, cs_low, listo_idx, listo_cnt, waited, viol;
        capture(sel, hold, extra, dist_at, dist_dato, bits, nrise, cs_low, listo_idx,
                listo_cnt, waited, viol);
        chk({tag, " frame bits"}, 32'(bits), 32'(exp_bits));
        chk({tag, " sclk rises"}, 32'(nrise), 32'd16);
        chk({tag, " cs low cycles"}, 32'(cs_low), 32'(exp_cs));
        chk({tag, " listo index"}, 32'(listo_idx), 32'(exp_cs + 1));
        chk({tag, " listo pulses"}, 32'(listo_cnt), 32'd1);
        chk({tag, " start wait"}, 32'(waited), 32'(exp_wait));
        chk({tag, " protocol violations"}, 32'(viol), 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic [11:0] dato;
        logic [15:0] frame;
        int          cs_low;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int          rises;
        logic        prev;
        int          bad;
        logic [11:0] d;
        int          sel;

        vecs[0] = '{sel: 0, dato: 12'hA5C, frame: 16'h3A5C, cs_low: 64};
        vecs[1] = '{sel: 0, dato: 12'h000, frame: 16'h3000, cs_low: 64};
        vecs[2] = '{sel: 0, dato: 12'hFFF, frame: 16'h3FFF, cs_low: 64};
        vecs[3] = '{sel: 1, dato: 12'h800, frame: 16'h3800, cs_low: 32};
        vecs[4] = '{sel: 1, dato: 12'h555, frame: 16'h3555, cs_low: 32};

        checks = 0;
        errors = 0;
        reset = 1'b0;
        inicio1 = 1'b1; dato1 = 12'hA5C;
        inicio2 = 1'b1; dato2 = 12'h800;

        // Reset held with a pending start request.
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (!cs1 || sclk1 || dac1 || listo1 || ocup1) bad++;
            if (!cs2 || sclk2 || dac2 || listo2 || ocup2) bad++;
        end
        chk("reset cs_out", 32'(cs1), 32'd1);
        chk("reset sclk_out", 32'(sclk1), 32'd0);
        chk("reset datoDAC", 32'(dac1), 32'd0);
        chk("reset listo", 32'(listo1), 32'd0);
        chk("reset ocupado", 32'(ocup1), 32'd0);
        chk("reset cycles with bad outputs", 32'(bad), 32'd0);
        inicio1 = 1'b0;
        inicio2 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle after reset cs_out", 32'(cs1), 32'd1);

        foreach (vecs[k]) begin
            start(vecs[k].sel, vecs[k].dato);
            check_frame($sformatf("vec%0d", k), vecs[k].sel, vecs[k].frame, vecs[k].cs_low,
                        1'b0, 3, 0, 12'h000, 0);
        end

        // Mid-frame data change and re-request are ignored.
        start(0, 12'hA5C);
        check_frame("midframe", 0, 16'h3A5C, 64, 1'b0, 5, 20, 12'h000, 0);

        // Held request: back-to-back frames with a two-cycle chip-select gap.
        start(0, 12'hFFF);
        check_frame("held1", 0, 16'h3FFF, 64, 1'b1, 0, 0, 12'h000, 0);
        dato1 = 12'h001;
        check_frame("held2", 0, 16'h3001, 64, 1'b1, 0, 0, 12'h000, 1);
        inicio1 = 1'b0;
        repeat (4) @(negedge clock);
        chk("held release cs_out", 32'(cs1), 32'd1);

        // Abort on the 8th SCLK rise.
        start(0, 12'h123);
        @(negedge clock);
        inicio1 = 1'b0;
        rises = 0;
        prev = sclk1;
        for (int i = 0; i < 200 && rises < 8; i++) begin
            @(negedge clock);
            if (sclk1 && !prev) rises++;
            prev = sclk1;
        end
        chk("abort reached 8th rise", 32'(rises), 32'd8);
        reset = 1'b0;
        @(negedge clock);
        chk("abort cs_out", 32'(cs1), 32'd1);
        chk("abort sclk_out", 32'(sclk1), 32'd0);
        chk("abort listo", 32'(listo1), 32'd0);
        chk("abort ocupado", 32'(ocup1), 32'd0);
        reset = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clock);
            if (listo1 || !cs1 || sclk1) bad++;
        end
        chk("abort not resumed", 32'(bad), 32'd0);
        start(0, 12'h9C3);
        check_frame("after abort", 0, 16'h39C3, 64, 1'b0, 3, 0, 12'h000, 0);

        // Randomized samples on both divider settings against the reference.
        repeat (6) begin
            sel = int'($urandom_range(0, 1));
            d = 12'($urandom);
            start(sel, d);
            check_frame($sformatf("rand sel%0d d%03h", sel, d), sel, model_frame(d),
                        model_cs_low(sel), 1'b0, 2, 0, 12'h000, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
